alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 1, meaning cycles the Alu operands are held before the result is captured (legal range 1..7).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide ports req_valid input 1, req_ready output 1, req_a input 3, req_b input 3, req_op input 2: operation request; operands are sign-magnitude, bit 2 = sign; op 00 add, 01 sub, 10 mul, 11 mod.
REQ-005 SHALL provide ports alu_a output 3, alu_b output 3, alu_s output 2: registered operand/select drive to the downstream Alu A/B/S.
REQ-006 SHALL provide ports alu_r input 5, alu_sf input 1, alu_zf input 1, alu_dzf input 1: Alu R/SF/ZF/DZF.
REQ-007 SHALL provide ports res_valid output 1, res_ready input 1, res_r output 5, res_sf output 1, res_zf output 1, res_dzf output 1, res_op output 2: registered result with handshake.
REQ-008 SHALL provide port busy output 1: high when FSM is not IDLE or the FIFO is non-empty.

Function
REQ-009 SHALL buffer requests in a 2-entry FIFO; push when req_valid && req_ready; req_ready = !full, with no full-bypass.
REQ-010 SHALL keep FIFO count unchanged on simultaneous push and pop when 1 entry is held.
REQ-011 SHALL implement FSM states IDLE, DRIVE, WAIT.
REQ-012 IDLE: if FIFO non-empty, pop head, load alu_a/alu_b/alu_s and a latched op, clear the settle counter, go DRIVE; else stay.
REQ-013 DRIVE: hold alu_* stable; at the edge ending the SETTLE_CYCLES-th DRIVE cycle, register alu_r/alu_sf/alu_zf/alu_dzf into res_*, set res_op, assert res_valid, go WAIT.
REQ-014 WAIT: hold res_* and res_valid stable until res_valid && res_ready; on that edge, deassert res_valid, then pop and load the next entry into DRIVE if the FIFO is non-empty (back-to-back), else go IDLE.
REQ-015 Latency: a request pushed into an empty FIFO with an idle FSM at edge N SHALL raise res_valid after edge N+1+SETTLE_CYCLES.
REQ-016 SHALL pass operands and results through unmodified (no sign-magnitude conversion or re-computation of flags).
REQ-017 Results SHALL be delivered in request order; none dropped or duplicated under any res_ready pattern.

Reset
REQ-018 While rst is high at a clock edge: FSM to IDLE, FIFO emptied, settle counter 0, res_valid 0, res_* 0, alu_* 0, req_ready 0, busy 0.
REQ-019 req_ready SHALL rise on the first edge after rst deasserts.
REQ-020 Reset mid-operation SHALL discard all buffered requests and any pending result without emitting res_valid.

Configuration
REQ-021 Macro ALU_ISSUE_DZ_COUNT_EN defined: add output dz_count (8 bit), incremented on each res handshake with res_dzf=1, saturating at 255, cleared by rst.
REQ-022 Macro ALU_ISSUE_DZ_COUNT_EN undefined: port dz_count and its logic are absent; all other behaviour is identical.

Verification
REQ-023 Push a=010 (+2), b=011 (+3), op 00, res_ready=1 -> res_valid after N+2 (SETTLE_CYCLES=1), res_r=00101, res_sf=0, res_zf=0, res_op=00.
REQ-024 Push a=010, b=010, op 01 -> res_r=00000, res_zf=1; then a=011, b=000, op 11 -> res_dzf=1, dz_count=1 (macro defined).
REQ-025 Hold res_ready=0, push 4 requests back-to-back -> first three accepted, req_ready=0 at the fourth; release res_ready -> all four results emerge in order.
REQ-026 Assert rst for one cycle while in DRIVE with 2 entries buffered -> no res_valid afterwards, busy=0, req_ready=1 on the next edge.
REQ-027 With macro defined, issue 260 mod-by-zero requests -> dz_count stops at 255; with SETTLE_CYCLES=3, single-request latency = N+4.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, Alu drive and result signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [1:0] req_op;

  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_s;
  logic [4:0] alu_r;
  logic       alu_sf;
  logic       alu_zf;
  logic       alu_dzf;

  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_r;
  logic       res_sf;
  logic       res_zf;
  logic       res_dzf;
  logic [1:0] res_op;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_r, alu_sf, alu_zf, alu_dzf,
    input  res_ready,
    output req_ready,
    output alu_a, alu_b, alu_s,
    output res_valid, res_r, res_sf, res_zf, res_dzf, res_op
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_r, alu_sf, alu_zf, alu_dzf,
    output res_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_s,
    input  res_valid, res_r, res_sf, res_zf, res_dzf, res_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - 2-entry request FIFO issuing operands to an external Alu and capturing its result
// Optional divide-by-zero result counter enabled by ALU_ISSUE_DZ_COUNT_EN.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic             busy
`ifdef ALU_ISSUE_DZ_COUNT_EN
  ,
  output logic [7:0]       dz_count
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_e;

  state_e     state_q, state_d;
  logic [2:0] settle_q, settle_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic       ready_q;
  logic [7:0] fifo_q [2];
  logic [7:0] head;

  logic [2:0] alu_a_q, alu_b_q;
  logic [1:0] alu_s_q;
  logic       res_valid_q;
  logic [4:0] res_r_q;
  logic       res_sf_q, res_zf_q, res_dzf_q;
  logic [1:0] res_op_q;

  logic push, pop, capture, res_hs;

  // req_ready is registered so it stays low during reset and rises one edge after release
  assign push   = bus.req_valid && ready_q;
  assign res_hs = res_valid_q && bus.res_ready;
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop      = 1'b1;
          settle_d = 3'd0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == 3'(SETTLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = WAIT;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      WAIT: begin
        if (res_hs) begin
          if (count_q != 2'd0) begin
            pop      = 1'b1;
            settle_d = 3'd0;
            state_d  = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus.req_op, bus.req_b, bus.req_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= 3'd0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ready_q     <= 1'b0;
      alu_a_q     <= 3'd0;
      alu_b_q     <= 3'd0;
      alu_s_q     <= 2'd0;
      res_valid_q <= 1'b0;
      res_r_q     <= 5'd0;
      res_sf_q    <= 1'b0;
      res_zf_q    <= 1'b0;
      res_dzf_q   <= 1'b0;
      res_op_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      ready_q  <= (count_d != 2'd2);
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        alu_a_q  <= head[2:0];
        alu_b_q  <= head[5:3];
        alu_s_q  <= head[7:6];
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        res_r_q     <= bus.alu_r;
        res_sf_q    <= bus.alu_sf;
        res_zf_q    <= bus.alu_zf;
        res_dzf_q   <= bus.alu_dzf;
        res_op_q    <= alu_s_q;
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_DZ_COUNT_EN
  logic [7:0] dz_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_count_q <= 8'd0;
    end else if (res_hs && res_dzf_q && (dz_count_q != 8'hff)) begin
      dz_count_q <= dz_count_q + 8'd1;
    end
  end

  assign dz_count = dz_count_q;
`endif

  assign bus.req_ready = ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_r     = res_r_q;
  assign bus.res_sf    = res_sf_q;
  assign bus.res_zf    = res_zf_q;
  assign bus.res_dzf   = res_dzf_q;
  assign bus.res_op    = res_op_q;
  assign busy          = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl (SETTLE_CYCLES 1 and 3 instances)
module tb_alu_issue_ctrl;
  logic clk;
  logic rst;
  logic busy, busy3;
  logic [7:0] dz_count, dz_count3;
  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_ctrl_if bus ();
  alu_issue_ctrl_if bus3 ();

  alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef ALU_ISSUE_DZ_COUNT_EN
    ,
    .dz_count(dz_count)
`endif
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3),
    .busy(busy3)
`ifdef ALU_ISSUE_DZ_COUNT_EN
    ,
    .dz_count(dz_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sign-magnitude Alu stand-in: {r[4:0], sf, zf, dzf}
  function automatic logic [7:0] alu_model(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    int av, bv, rv, mag;
    logic dz;
    av = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
    bv = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
    dz = 1'b0;
    case (s)
      2'b00: rv = av + bv;
      2'b01: rv = av - bv;
      2'b10: rv = av * bv;
      default: begin
        if (bv == 0) begin
          rv = 0;
          dz = 1'b1;
        end else begin
          rv = av % bv;
        end
      end
    endcase
    mag = (rv < 0) ? -rv : rv;
    return {rv < 0, 4'(mag), rv < 0, rv == 0, dz};
  endfunction

  assign {bus.alu_r, bus.alu_sf, bus.alu_zf, bus.alu_dzf}     = alu_model(bus.alu_a, bus.alu_b, bus.alu_s);
  assign {bus3.alu_r, bus3.alu_sf, bus3.alu_zf, bus3.alu_dzf} = alu_model(bus3.alu_a, bus3.alu_b, bus3.alu_s);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                        input logic [4:0] er, input logic esf, input logic ezf, input logic edzf);
    int lat;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    bus.res_ready = 1'b1;
    check({tag, "_ready"}, bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_r"}, bus.res_r, er);
    check({tag, "_sf"}, bus.res_sf, esf);
    check({tag, "_zf"}, bus.res_zf, ezf);
    check({tag, "_dzf"}, bus.res_dzf, edzf);
    check({tag, "_op"}, bus.res_op, op);
    check({tag, "_alu_b"}, bus.alu_b, b);
    @(negedge clk);
    check({tag, "_vdrop"}, bus.res_valid, 0);
  endtask

  logic [2:0] bp_a [4] = '{3'b001, 3'b001, 3'b010, 3'b011};
  logic [2:0] bp_b [4] = '{3'b001, 3'b010, 3'b010, 3'b011};
  logic [4:0] bp_r [4] = '{5'b00010, 5'b00011, 5'b00100, 5'b00110};

  initial begin
    int got, cyc, lat, seen;
    logic drop;
    rst = 1'b1;
    bus.req_valid = 1'b0;  bus.req_a = '0;  bus.req_b = '0;  bus.req_op = '0;  bus.res_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0; bus3.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_res_r", bus.res_r, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", bus.req_ready, 1);

    run_op("add", 3'b010, 3'b011, 2'b00, 5'b00101, 1'b0, 1'b0, 1'b0);
    run_op("subz", 3'b010, 3'b010, 2'b01, 5'b00000, 1'b0, 1'b1, 1'b0);
    run_op("moddz", 3'b011, 3'b000, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b1);
`ifdef ALU_ISSUE_DZ_COUNT_EN
    check("dz_count1", dz_count, 1);
`endif
    run_op("subn", 3'b001, 3'b011, 2'b01, 5'b10010, 1'b1, 1'b0, 1'b0);
    run_op("mul", 3'b110, 3'b011, 2'b10, 5'b10110, 1'b1, 1'b0, 1'b0);
    run_op("mod", 3'b011, 3'b010, 2'b11, 5'b00001, 1'b0, 1'b0, 1'b0);

    // backpressure: three accepted, fourth stalls until results drain
    bus.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.req_a = bp_a[k]; bus.req_b = bp_b[k]; bus.req_op = 2'b00; bus.req_valid = 1'b1;
      check($sformatf("bp_ready%0d", k), bus.req_ready, (k < 3) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_ready_hold", bus.req_ready, 0);
    bus.res_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 80) begin
      drop = bus.req_valid && bus.req_ready;
      if (bus.res_valid) begin
        check($sformatf("bp_r%0d", got), bus.res_r, bp_r[got]);
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      if (drop) bus.req_valid = 1'b0;
      cyc++;
    end
    check("bp_count", got, 4);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);

    // reset while DRIVE holds one op and two are buffered (SETTLE_CYCLES=3 instance)
    bus3.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus3.req_a = bp_a[k]; bus3.req_b = bp_b[k]; bus3.req_op = 2'b00; bus3.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus3.req_valid = 1'b0;
    check("mid_busy", busy3, 1);
    check("mid_ready", bus3.req_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", busy3, 0);
    check("mr_valid", bus3.res_valid, 0);
    check("mr_ready_low", bus3.req_ready, 0);
`ifdef ALU_ISSUE_DZ_COUNT_EN
    check("mr_dz_count", dz_count, 0);
`endif
    @(negedge clk);
    check("mr_ready_up", bus3.req_ready, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus3.res_valid) seen++;
      @(negedge clk);
    end
    check("mr_no_result", seen, 0);
    check("mr_busy_after", busy3, 0);

    // single-request latency with SETTLE_CYCLES=3
    bus3.req_a = 3'b001; bus3.req_b = 3'b001; bus3.req_op = 2'b00; bus3.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    lat = 0;
    while (!bus3.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("s3_lat", lat, 4);
    check("s3_r", bus3.res_r, 5'b00010);
    @(negedge clk);
    check("s3_vdrop", bus3.res_valid, 0);

`ifdef ALU_ISSUE_DZ_COUNT_EN
    bus.res_ready = 1'b1;
    bus.req_a = 3'b011; bus.req_b = 3'b000; bus.req_op = 2'b11;
    for (int k = 0; k < 260; k++) begin
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      cyc = 0;
      while (!bus.res_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
    end
    check("dz_sat", dz_count, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
